mcpu_loader: RTL and testbench
==============================

# mcpu_loader

Program-load and run sequencer for the 8-bit accumulator CPU and its 64-byte memory. Holds the CPU in reset, streams a program image from a host byte port into memory, releases the CPU, stops it on halt detection or cycle budget, then optionally streams the memory image back out. Sits between the CPU core, the single-port program RAM and the host/debug interface, and owns the RAM address/data mux.

## Interface
Parameters:
- AW, 6, memory address width (depth 2^AW)
- HALT_CNT, 3, consecutive identical CPU addresses that declare halt (min 3)
- CW, 16, run-cycle counter width
- MAX_CYCLES, 16'hFFFF, cycle budget before timeout

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  pulse: begin load (accepted in IDLE/DONE only)
- abort  in  1  pulse: return to IDLE from any state
- in_valid / in_ready  in/out  1  host load stream handshake
- in_data  in  8  program byte
- in_last  in  1  final program byte
- out_valid / out_ready  out/in  1  dump stream handshake
- out_data  out  8  dumped byte
- out_last  out  1  marks byte at address 2^AW-1
- cpu_adr  in  AW  CPU address bus
- cpu_dout  in  8  CPU store data
- cpu_st  in  1  high for the whole CPU store cycle
- cpu_rst_n  out  1  CPU reset, active-low, registered
- mem_adr  out  AW  RAM address (async read)
- mem_wdata  out  8  RAM write data
- mem_we  out  1  RAM write, taken at posedge clk
- mem_rdata  in  8  RAM read data
- busy, done, halted, timeout  out  1  status
- run_cycles  out  CW  cycles CPU spent out of reset

## Operation
- States: IDLE, LOAD, RUN, DUMP, DONE. Reset: IDLE; all outputs 0, cpu_rst_n=0, run_cycles=0.
- IDLE: start -> LOAD; ptr<=0, halted/timeout/run_cycles cleared.
- LOAD: in_ready=1; on in_valid&in_ready: mem_we=1, mem_adr=ptr, mem_wdata=in_data, ptr++. Exit to RUN after accepting in_last or the byte at ptr=2^AW-1 (no wrap; in_ready low from next cycle). Unwritten locations keep old contents.
- RUN: cpu_rst_n=1; mem_adr=cpu_adr, mem_wdata=cpu_dout, mem_we=cpu_st. run_cycles increments every cycle cpu_rst_n=1, saturating.
- Halt detector: counts consecutive cycles with cpu_adr equal to previous cycle's; reaching HALT_CNT equal samples sets halted. run_cycles reaching MAX_CYCLES sets timeout. Same cycle: both flags set. Either -> leave RUN, cpu_rst_n=0.
- DUMP: ptr<=0 on entry; out_valid=1, mem_adr=ptr, out_data=mem_rdata; ptr++ on out_valid&out_ready; out_last at ptr=2^AW-1, its acceptance -> DONE.
- DONE: done=1; start -> LOAD (flags cleared); status held otherwise.
- abort in LOAD/RUN/DUMP/DONE -> IDLE next cycle, cpu_rst_n=0, handshakes dropped, flags retained; abort wins over start.
- busy=1 in LOAD, RUN, DUMP. mem_we=0 outside LOAD/RUN.

## Timing
- start at edge n -> LOAD at n+1, in_ready high in cycle n+1.
- Last load byte accepted at edge m -> RUN at m+1; cpu_rst_n high from m+1 (registered); first CPU fetch at address 0 in cycle m+1.
- Halt: HALT_CNT-th equal sample at edge k -> cpu_rst_n low and state DUMP at k+1.
- Dump: one byte per cycle with out_ready held high; 2^AW cycles from DUMP entry to DONE.
- Async rst mid-operation: immediate IDLE; RAM contents not touched.

## Configuration
- MCPU_LOADER_DUMP_EN defined: DUMP state present as above.
- Undefined: RUN exits straight to DONE; out_valid, out_last, out_data tied 0.

## Test plan
- Load 4 bytes {0x3E,0x7F,0xC3,...} with in_last on 4th -> mem writes at 0..3, in_ready low after, cpu_rst_n rises next cycle.
- Load "JCC 0x05" at 0x05 path: program ending in self-jump -> halted=1 after 3 equal cpu_adr cycles, run_cycles exact, dump byte at store target holds stored value.
- Load 64 bytes without in_last -> RUN entered after 64th byte, 65th in_valid not accepted.
- MAX_CYCLES=20, non-halting loop -> timeout=1, halted=0, run_cycles=20.
- abort mid-DUMP with out_ready stalled -> IDLE next cycle, out_valid=0; then start -> LOAD, flags cleared.
- Build without MCPU_LOADER_DUMP_EN -> halt goes to DONE in one cycle, out_valid never high.

Source files
------------

// File: rtl/mcpu_loader.sv
// Program-load / run / dump sequencer for the 8-bit accumulator CPU and its RAM.
// Define MCPU_LOADER_DUMP_EN to include the memory dump-back stage.
module mcpu_loader #(
  parameter int unsigned   AW         = 6,
  parameter int unsigned   HALT_CNT   = 3,
  parameter int unsigned   CW         = 16,
  parameter logic [CW-1:0] MAX_CYCLES = CW'(16'hFFFF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic          out_last,
  input  logic [AW-1:0] cpu_adr,
  input  logic [7:0]    cpu_dout,
  input  logic          cpu_st,
  output logic          cpu_rst_n,
  output logic [AW-1:0] mem_adr,
  output logic [7:0]    mem_wdata,
  output logic          mem_we,
  input  logic [7:0]    mem_rdata,
  output logic          busy,
  output logic          done,
  output logic          halted,
  output logic          timeout,
  output logic [CW-1:0] run_cycles
);

  localparam int unsigned HW       = $clog2(HALT_CNT + 1);
  localparam logic [AW-1:0] PTR_LAST = '1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DUMP, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] prev_adr_q;
  logic [HW-1:0] run_len_q, run_len_d;
  logic [CW-1:0] run_cycles_q, run_cycles_d;
  logic          halted_q, halted_d;
  logic          timeout_q, timeout_d;
  logic          cpu_rst_n_q;
  logic          hit_halt, hit_to;

  // State register plus status/pointer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      prev_adr_q   <= '0;
      run_len_q    <= '0;
      run_cycles_q <= '0;
      halted_q     <= 1'b0;
      timeout_q    <= 1'b0;
      cpu_rst_n_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      prev_adr_q   <= cpu_adr;
      run_len_q    <= run_len_d;
      run_cycles_q <= run_cycles_d;
      halted_q     <= halted_d;
      timeout_q    <= timeout_d;
      cpu_rst_n_q  <= (state_d == S_RUN);
    end
  end

  // Next-state, RAM mux and halt/timeout detection
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    run_len_d    = '0;
    run_cycles_d = run_cycles_q;
    halted_d     = halted_q;
    timeout_d    = timeout_q;
    mem_adr      = ptr_q;
    mem_wdata    = '0;
    mem_we       = 1'b0;
    hit_halt     = 1'b0;
    hit_to       = 1'b0;

    if (cpu_rst_n_q && (run_cycles_q != '1)) begin
      run_cycles_d = run_cycles_q + CW'(1);
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start && !abort) begin
          state_d      = S_LOAD;
          ptr_d        = '0;
          halted_d     = 1'b0;
          timeout_d    = 1'b0;
          run_cycles_d = '0;
        end
      end
      S_LOAD: begin
        mem_wdata = in_data;
        mem_we    = in_valid;
        if (in_valid) begin
          ptr_d = ptr_q + AW'(1);
          if (in_last || (ptr_q == PTR_LAST)) begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        mem_adr   = cpu_adr;
        mem_wdata = cpu_dout;
        mem_we    = cpu_st;
        // run_len_q == 0 marks the first RUN cycle, where there is no previous sample
        run_len_d = ((run_len_q != '0) && (cpu_adr == prev_adr_q)) ?
                    run_len_q + HW'(1) : HW'(1);
        hit_halt  = (run_len_d == HW'(HALT_CNT));
        hit_to    = (run_cycles_d == MAX_CYCLES);
        if (!abort && (hit_halt || hit_to)) begin
          halted_d  = halted_q | hit_halt;
          timeout_d = timeout_q | hit_to;
          ptr_d     = '0;
`ifdef MCPU_LOADER_DUMP_EN
          state_d   = S_DUMP;
`else
          state_d   = S_DONE;
`endif
        end
      end
      S_DUMP: begin
`ifdef MCPU_LOADER_DUMP_EN
        if (out_ready) begin
          ptr_d = ptr_q + AW'(1);
          if (ptr_q == PTR_LAST) begin
            state_d = S_DONE;
          end
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d = S_IDLE;
    end
  end

  assign in_ready   = (state_q == S_LOAD);
  assign busy       = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_DUMP);
  assign done       = (state_q == S_DONE);
  assign halted     = halted_q;
  assign timeout    = timeout_q;
  assign run_cycles = run_cycles_q;
  assign cpu_rst_n  = cpu_rst_n_q;

`ifdef MCPU_LOADER_DUMP_EN
  assign out_valid = (state_q == S_DUMP);
  assign out_data  = out_valid ? mem_rdata : 8'h00;
  assign out_last  = out_valid && (ptr_q == PTR_LAST);
`else
  logic unused_c;
  assign unused_c  = ^{mem_rdata, out_ready};
  assign out_valid = 1'b0;
  assign out_data  = 8'h00;
  assign out_last  = 1'b0;
`endif

endmodule

// File: tb/tb_mcpu_loader.sv
// Randomized bench for mcpu_loader: RAM model, CPU address-trace driver and
// a reference model of load/halt/timeout/dump outcomes.
module tb_mcpu_loader;

  localparam int unsigned AW   = 6;
  localparam int unsigned HC   = 3;
  localparam int unsigned CW   = 16;
  localparam int          MAXC = 20;
  localparam int          DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort;
  logic          in_valid, in_ready, in_last;
  logic [7:0]    in_data;
  logic          out_valid, out_ready, out_last;
  logic [7:0]    out_data;
  logic [AW-1:0] cpu_adr;
  logic [7:0]    cpu_dout;
  logic          cpu_st, cpu_rst_n;
  logic [AW-1:0] mem_adr;
  logic [7:0]    mem_wdata, mem_rdata;
  logic          mem_we;
  logic          busy, done, halted, timeout;
  logic [CW-1:0] run_cycles;

  mcpu_loader #(.AW(AW), .HALT_CNT(HC), .CW(CW), .MAX_CYCLES(16'd20)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .cpu_adr(cpu_adr), .cpu_dout(cpu_dout), .cpu_st(cpu_st), .cpu_rst_n(cpu_rst_n),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .halted(halted), .timeout(timeout), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  // Single-port RAM with async read
  logic [7:0] ram [DEPTH];
  assign mem_rdata = ram[mem_adr];
  always @(posedge clk) if (mem_we) ram[mem_adr] <= mem_wdata;

  int ov_seen = 0;
  always @(posedge clk) if (out_valid) ov_seen <= ov_seen + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]    exp_mem [DEPTH];
  logic [AW-1:0] seq [32];
  logic          st_a [32];
  logic [7:0]    dv [32];
  int            len;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] adr_at(input int i);
    return seq[(i < len) ? i : len - 1];
  endfunction

  // Address trace: L non-repeating addresses, then a constant address (or none if L<0)
  task automatic gen_seq(input int l, input bit halting);
    logic [AW-1:0] a;
    len = halting ? l + HC : 32;
    for (int i = 0; i < len; i++) begin
      a = AW'($urandom);
      if (!halting || i < l) begin
        if (i > 0 && a == seq[i-1]) a = a + AW'(1);
      end else if (i == l) begin
        if (l > 0 && a == seq[l-1]) a = a + AW'(1);
      end else begin
        a = seq[l];
      end
      seq[i]  = a;
      st_a[i] = ($urandom % 4) == 0;
      dv[i]   = 8'($urandom);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_ready", 32'(in_ready), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
    check("start_halted_clr", 32'(halted), 32'd0);
    check("start_timeout_clr", 32'(timeout), 32'd0);
    check("start_rc_clr", 32'(run_cycles), 32'd0);
  endtask

  task automatic do_load(input int n, input bit use_last, input bit fixed);
    logic [7:0] fx [4];
    int idx, guard;
    bit acc;
    fx[0] = 8'h3E; fx[1] = 8'h7F; fx[2] = 8'hC3; fx[3] = 8'h05;
    idx = 0;
    guard = 0;
    while (idx < n && guard < 2000) begin
      in_valid = ($urandom % 4) != 0;
      in_data  = fixed ? fx[idx % 4] : 8'($urandom);
      in_last  = use_last && (idx == n - 1);
      check("load_in_ready", 32'(in_ready), 32'd1);
      acc = in_valid && in_ready;
      if (acc) exp_mem[idx] = in_data;
      tick();
      if (acc) idx++;
      guard++;
    end
    if (guard >= 2000) check("load_budget", 32'(idx), 32'(n));
    in_last  = 1'b0;
    in_valid = !use_last;  // full-depth load keeps offering a 65th byte
    check("run_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    check("run_in_ready_low", 32'(in_ready), 32'd0);
  endtask

  task automatic scenario(input int kind, input int t);
    int l, a, halt_i, rc, j, k, idx, guard, mism, abort_idx;
    bit eh, et, dump_abort;
    logic [AW-1:0] x0, x1, x2;
    dump_abort = 0;
    a = -1;
    case (kind)
      1:       l = -1;
      3:       l = $urandom_range(4, 12);
      4:       l = 17;
      default: l = $urandom_range(0, 12);
    endcase
    gen_seq(l, l >= 0);
    if (kind == 3) a = $urandom_range(0, l);
`ifdef MCPU_LOADER_DUMP_EN
    dump_abort = (kind == 5);
`endif

    // Reference outcome from the address trace
    halt_i = 1000;
    for (int i = HC - 1; i < 200; i++) begin
      x0 = adr_at(i); x1 = adr_at(i - 1); x2 = adr_at(i - 2);
      if (x0 == x1 && x1 == x2) begin halt_i = i; break; end
    end
    rc = (halt_i + 1 < MAXC) ? halt_i + 1 : MAXC;
    eh = (halt_i + 1 <= MAXC);
    et = (halt_i + 1 >= MAXC);
    if (a >= 0) begin rc = a + 1; eh = 0; et = 0; end

    do_start();
    if (kind == 2) do_load(DEPTH, 1'b0, 1'b0);
    else           do_load((t == 0) ? 4 : $urandom_range(1, 63), 1'b1, t == 0);

    j = 0;
    while (cpu_rst_n && j < 200) begin
      k = (j < len) ? j : len - 1;
      cpu_adr  = seq[k];
      cpu_st   = st_a[k];
      cpu_dout = dv[k];
      if (st_a[k]) exp_mem[seq[k]] = dv[k];
      abort = (j == a);
      tick();
      j++;
    end
    cpu_st = 1'b0; abort = 1'b0; in_valid = 1'b0;
    check("run_len", 32'(j), 32'(rc));
    check("run_cycles", 32'(run_cycles), 32'(rc));
    check("halted", 32'(halted), 32'(eh));
    check("timeout", 32'(timeout), 32'(et));
    check("cpu_rst_n_low", 32'(cpu_rst_n), 32'd0);
    mism = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== exp_mem[i]) mism++;
    check("ram_image", 32'(mism), 32'd0);

    if (a >= 0) begin
      check("abort_run_busy", 32'(busy), 32'd0);
      check("abort_run_done", 32'(done), 32'd0);
      return;
    end

`ifdef MCPU_LOADER_DUMP_EN
    check("dump_busy", 32'(busy), 32'd1);
    abort_idx = $urandom_range(1, 60);
    idx = 0;
    guard = 0;
    while (idx < DEPTH && guard < 1000) begin
      if (dump_abort && idx == abort_idx) begin
        out_ready = 1'b0;
        tick(); tick();
        check("dump_stall_valid", 32'(out_valid), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_dump_valid", 32'(out_valid), 32'd0);
        check("abort_dump_busy", 32'(busy), 32'd0);
        check("abort_dump_halted", 32'(halted), 32'(eh));
        check("abort_dump_rc", 32'(run_cycles), 32'(rc));
        return;
      end
      out_ready = ($urandom % 3) != 0;
      check("dump_valid", 32'(out_valid), 32'd1);
      if (out_ready) begin
        check("dump_data", 32'(out_data), 32'(exp_mem[idx]));
        check("dump_last", 32'(out_last), 32'(idx == DEPTH - 1));
      end
      tick();
      if (out_ready) idx++;
      guard++;
    end
    out_ready = 1'b0;
    if (guard >= 1000) check("dump_budget", 32'(idx), 32'(DEPTH));
`endif
    check("done", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_out_valid", 32'(out_valid), 32'd0);
    tick();
    check("done_held", 32'(done), 32'd1);
    check("done_halted_held", 32'(halted), 32'(eh));
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    cpu_adr = '0; cpu_dout = '0; cpu_st = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = 8'($urandom);
      exp_mem[i] = ram[i];
    end
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_run_cycles", 32'(run_cycles), 32'd0);
    check("rst_flags", 32'({halted, timeout}), 32'd0);
    rst = 1'b1;
    tick();

    for (int t = 0; t < 14; t++) scenario(t % 6, t);

    // Async reset in the middle of a load
    do_start();
    in_valid = 1'b1; in_data = 8'h11; in_last = 1'b0;
    tick();
    exp_mem[0] = 8'h11;
    rst = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("async_rst_ram0", 32'(ram[0]), 32'(exp_mem[0]));

`ifndef MCPU_LOADER_DUMP_EN
    check("out_valid_never", 32'(ov_seen), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
